// File: rtl/nibble_serializer.sv
// nibble_serializer: valid/ready parallel load, one frame bit per clock out.
// Optional serial CRC tail per frame when CRC_APPEND_EN is defined.
module nibble_serializer #(
    parameter int unsigned      DATA_W    = 4,
    parameter bit               LSB_FIRST = 1'b1,
    parameter int unsigned      CRC_W     = 3,
    parameter logic [CRC_W-1:0] CRC_POLY  = 3'b011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              sout,
    output logic              sout_valid,
    output logic              sout_last,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W + CRC_W + 1);

`ifdef CRC_APPEND_EN
    localparam int unsigned FRAME = DATA_W + CRC_W;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CRC
    } state_t;
`else
    localparam int unsigned FRAME = DATA_W;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
    } state_t;
`endif

    localparam logic [CNT_W-1:0] PAY_LEN = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] FRM_LEN = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    function automatic logic [CRC_W-1:0] crc_step(
        input logic [CRC_W-1:0] c,
        input logic             b
    );
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    state_t            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sout_q;
    logic              sout_valid_q;
    logic              sout_last_q;

    logic              accept;
    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] data_rest;
    logic [DATA_W-1:0] shreg_adv;
    logic [CNT_W-1:0]  cnt_inc;

    assign load_ready = (state_q == ST_IDLE) | sout_last_q;
    assign busy       = (state_q != ST_IDLE);
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign sout_last  = sout_last_q;

    // Shift register holds the payload bits not yet sent, next bit at the edge
    always_comb begin
        accept  = load_valid & load_ready;
        cnt_inc = cnt_q + 1'b1;
        if (LSB_FIRST) begin
            first_bit = data[0];
            data_rest = data >> 1;
            next_bit  = shreg_q[0];
            shreg_adv = shreg_q >> 1;
        end else begin
            first_bit = data[DATA_W-1];
            data_rest = data << 1;
            next_bit  = shreg_q[DATA_W-1];
            shreg_adv = shreg_q << 1;
        end
    end

`ifdef CRC_APPEND_EN
    localparam logic [CRC_W-1:0] CRC_MSB = {1'b1, {(CRC_W-1){1'b0}}};

    logic [CRC_W-1:0] crc_q;
    logic             crc_bit;

    // CRC stays frozen during the tail; the counter selects the bit, MSB first
    always_comb begin
        crc_bit = |(crc_q & (CRC_MSB >> (cnt_q - PAY_LEN)));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
`ifdef CRC_APPEND_EN
            crc_q        <= '0;
`endif
        end else if (accept) begin
            state_q      <= ST_SHIFT;
            shreg_q      <= data_rest;
            cnt_q        <= ONE;
            sout_q       <= first_bit;
            sout_valid_q <= 1'b1;
            sout_last_q  <= (FRM_LEN == ONE);
`ifdef CRC_APPEND_EN
            crc_q        <= crc_step('0, first_bit);
`endif
        end else if (state_q == ST_IDLE || sout_last_q) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
        end else if (cnt_q < PAY_LEN) begin
            shreg_q      <= shreg_adv;
            cnt_q        <= cnt_inc;
            sout_q       <= next_bit;
            sout_last_q  <= (cnt_inc == FRM_LEN);
`ifdef CRC_APPEND_EN
            crc_q        <= crc_step(crc_q, next_bit);
        end else begin
            state_q      <= ST_CRC;
            cnt_q        <= cnt_inc;
            sout_q       <= crc_bit;
            sout_last_q  <= (cnt_inc == FRM_LEN);
`endif
        end
    end

endmodule
